// File: rtl/hyper_pipe_pkg.sv
// Shared constants and helpers for the hyper-pipelined sender/receiver pair.
package hyper_pipe_pkg;

  // Default worst-case in-flight words; sender and receiver must agree on it.
  localparam int HP_ROUND_TRIP = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth, input int round_trip);
    return (depth > 1) && ((depth & (depth - 1)) == 0) && (depth >= round_trip + 2);
  endfunction

endpackage

// File: rtl/hyper_pipe_rx_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module hyper_pipe_rx_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; occupancy tracking gates their use.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hyper_pipe_rx_fifo.sv
// Receive-side skid FIFO for a hyper-pipelined valid/data path with registered
// almost_full backpressure and a show-ahead valid/ready consumer interface.
module hyper_pipe_rx_fifo
  import hyper_pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 16,
  parameter int ROUND_TRIP = HP_ROUND_TRIP,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             almost_full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW        = $clog2(DEPTH);
  localparam int AF_THRESH = DEPTH - ROUND_TRIP;

  if (!depth_ok(DEPTH, ROUND_TRIP)) begin : g_bad_cfg
    $fatal(1, "hyper_pipe_rx_fifo: DEPTH must be a power of two and >= ROUND_TRIP+2");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic          pop, push_ok;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok   = in_valid && ((count < CW'(DEPTH)) || pop);

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      almost_full <= (count_next >= CW'(AF_THRESH));
      if (in_valid && !push_ok) overflow <= 1'b1;
    end
  end

  hyper_pipe_rx_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: doc/hyper_pipe_rx_fifo.md
Name: hyper_pipe_rx_fifo

Overview:
- Receive-side buffer at the far end of a hyper-pipelined valid/data path (forward hyper pipes carry in_valid/in_data; a return hyper pipe carries almost_full to the sender).
- Absorbs the words still in flight after it raises almost_full, so the path needs no per-stage ready.
- Presents a show-ahead valid/ready interface to the consuming stage.
- Flags overflow if the sender ignored almost_full.

Parameters:
WIDTH, 64, data word width in bits.
DEPTH, 16, storage entries; power of two; must satisfy DEPTH >= ROUND_TRIP + 2.
ROUND_TRIP, 4, worst-case words that can still arrive after almost_full asserts (forward + return pipe stages + sender reaction).
AF_THRESH, DEPTH-ROUND_TRIP, derived (localparam); occupancy at or above which almost_full asserts.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  word present on in_data this cycle (no ready; always accepted if space).
in_data  input  WIDTH  incoming word.
almost_full  output  1  registered backpressure to the sender via the return hyper pipe.
out_valid  output  1  head word available (count != 0).
out_data  output  WIDTH  head word, valid when out_valid.
out_ready  input  1  consumer takes the head when out_valid && out_ready.
count  output  $clog2(DEPTH+1)  current occupancy.
overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset (async assert, released synchronously by the integrator's reset sync): wr_ptr = rd_ptr = 0, count = 0, almost_full = 0, overflow = 0. out_valid = 0. Storage contents are not reset. Reset mid-traffic discards all buffered words.
- pop = out_valid && out_ready.
- push_ok = in_valid && (count < DEPTH || pop). A write when full with a simultaneous pop is accepted.
- drop = in_valid && !push_ok. The word is discarded, no state changes except overflow <= 1. Overflow is cleared only by rst.
- On push_ok: mem[wr_ptr] <= in_data; wr_ptr increments and wraps naturally at DEPTH (pointer width $clog2(DEPTH)).
- On pop: rd_ptr increments with the same wrap.
- count_next = count + push_ok - pop. Both in the same cycle leave count unchanged. count never exceeds DEPTH and never underflows (pop requires out_valid).
- almost_full <= (count_next >= AF_THRESH), registered. It asserts in the cycle after the push that reaches AF_THRESH and deasserts in the cycle after count drops below it.
- Output path is show-ahead:
  - out_data = mem[rd_ptr] (combinational read of the register array).
  - out_valid = (count != 0).
- Write-to-read latency is 1 cycle. A word pushed into an empty FIFO appears on out_valid/out_data the next cycle. There is no same-cycle bypass.
- out_data is undefined when out_valid = 0. Benches must not check it then.
- With a sender that honours almost_full within ROUND_TRIP cycles, overflow never sets. This is guaranteed by AF_THRESH + ROUND_TRIP <= DEPTH.
- Elaboration checks: DEPTH is a power of two; DEPTH >= ROUND_TRIP + 2. Failure is a $fatal at elaboration.

Decomposition:
- Shared package hyper_pipe_pkg:
  - clog2-based width helper for count.
  - Default ROUND_TRIP constant so sender and receiver agree.
  - Elaboration-check function validating DEPTH/ROUND_TRIP.
- One natural sub-module: hyper_pipe_rx_mem (register-array storage, one write port, one async read port), instantiated once.
- The return almost_full hyper pipe and forward hyper pipes are instantiated by the parent, not inside this block.

Test Plan:
1. Reset/idle (DEPTH=8, ROUND_TRIP=3, AF_THRESH=5): assert rst mid-clock -> count=0, out_valid=0, almost_full=0, overflow=0 immediately, without waiting for an edge.
2. Single word: push 0xA5 into empty FIFO with out_ready=1 -> out_valid=1 with out_data=0xA5 exactly one cycle later, popped that cycle, count returns to 0.
3. Threshold: out_ready=0, push 5 words -> almost_full=1 in the cycle after the 5th push. Pop one -> almost_full=0 the cycle after count=4.
4. Full with simultaneous pop: fill to 8, then in_valid=1 and out_ready=1 same cycle -> write accepted, count stays 8, overflow stays 0, order preserved across pointer wrap (write 20 sequential words, read 0..19).
5. Overflow: fill to 8, out_ready=0, push 0xFF -> word dropped, count=8, overflow=1 sticky until rst. Subsequent reads return the original 8 words in order.
6. Backpressure compliance: random traffic with a model sender stopping ROUND_TRIP=3 cycles after seeing almost_full, 10k cycles -> overflow never asserts, output sequence equals input sequence.
